// File: rtl/tdm_demux4.sv
// 1-to-4 time-division demultiplexer: steers a framed serial sample stream into
// four registered channel outputs, tracking frame alignment with a hunt/lock FSM.
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       yv,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              slot_q, slot_d;
  logic [3:0]              yv_q, yv_d;
  logic                    frame_done_q, frame_done_d;
  logic                    sync_err_q, sync_err_d;
  logic [3:0]              wr_en;
  logic [3:0][WIDTH-1:0]   y_q;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    wr_en        = 4'b0000;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame) begin
            wr_en   = 4'b0001;
            slot_d  = 2'd1;
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (frame) begin
            // A marker anywhere but slot 0 truncates the old frame and resyncs.
            sync_err_d = (slot_q != 2'd0);
            wr_en      = 4'b0001;
            slot_d     = 2'd1;
          end else if (slot_q == 2'd0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else begin
            wr_en        = 4'b0001 << slot_q;
            slot_d       = slot_q + 2'd1;
            frame_done_d = (slot_q == 2'd3);
          end
        end
        default: state_d = HUNT;
      endcase
    end

    yv_d = wr_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= 2'd0;
      yv_q         <= 4'b0000;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      yv_q         <= yv_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      logic [WIDTH-1:0] y_d;

      always_comb begin
        y_d = wr_en[gi] ? din : y_q[gi];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q[gi] <= '0;
        end else begin
          y_q[gi] <= y_d;
        end
      end
    end
  endgenerate

  assign y0         = y_q[0];
  assign y1         = y_q[1];
  assign y2         = y_q[2];
  assign y3         = y_q[3];
  assign yv         = yv_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: hand-computed vectors covering reset, clean
// frames, gaps, missing/early markers and back-to-back frames.
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       frame;
  logic [7:0] y0, y1, y2, y3;
  logic [3:0] yv;
  logic       frame_done;
  logic       sync_err;
  logic       locked;

  int check_cnt;
  int pass_cnt;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame      (frame),
    .y0         (y0),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .yv         (yv),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    check_cnt++;
    if (obs === exp_v) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of input at the falling edge, then settle just past the rising edge.
  task automatic send(input logic [7:0] d, input logic v, input logic f);
    @(negedge clk);
    din       = d;
    din_valid = v;
    frame     = f;
    @(posedge clk);
    #1;
    $display("t=%0t din=%h v=%b f=%b -> y=%h %h %h %h yv=%b fd=%b se=%b lk=%b",
             $time, d, v, f, y0, y1, y2, y3, yv, frame_done, sync_err, locked);
  endtask

  task automatic chk_pulses(input string tag, input logic [3:0] e_yv, input logic e_fd,
                            input logic e_se, input logic e_lk);
    chk({tag, ".yv"}, {28'd0, yv}, {28'd0, e_yv});
    chk({tag, ".fd"}, {31'd0, frame_done}, {31'd0, e_fd});
    chk({tag, ".se"}, {31'd0, sync_err}, {31'd0, e_se});
    chk({tag, ".lk"}, {31'd0, locked}, {31'd0, e_lk});
  endtask

  task automatic chk_y(input string tag, input logic [31:0] e_y);
    chk({tag, ".y"}, {y3, y2, y1, y0}, e_y);
  endtask

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    rst_n     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    frame     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_y("rst", 32'h0000_0000);
    chk_pulses("rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean frame
    send(8'hA1, 1'b1, 1'b1); chk_pulses("c0", 4'b0001, 1'b0, 1'b0, 1'b1); chk_y("c0", 32'h0000_00A1);
    send(8'hB2, 1'b1, 1'b0); chk_pulses("c1", 4'b0010, 1'b0, 1'b0, 1'b1);
    send(8'hC3, 1'b1, 1'b0); chk_pulses("c2", 4'b0100, 1'b0, 1'b0, 1'b1);
    send(8'hD4, 1'b1, 1'b0); chk_pulses("c3", 4'b1000, 1'b1, 1'b0, 1'b1); chk_y("c3", 32'hD4C3_B2A1);
    send(8'hFF, 1'b0, 1'b1); chk_pulses("cidle", 4'b0000, 1'b0, 1'b0, 1'b1); chk_y("cidle", 32'hD4C3_B2A1);

    // Gaps between samples; frame ignored while invalid
    send(8'hE1, 1'b1, 1'b1); chk_pulses("g0", 4'b0001, 1'b0, 1'b0, 1'b1);
    send(8'h99, 1'b0, 1'b0); chk_pulses("g0i", 4'b0000, 1'b0, 1'b0, 1'b1);
    send(8'hE2, 1'b1, 1'b0); chk_pulses("g1", 4'b0010, 1'b0, 1'b0, 1'b1);
    send(8'h98, 1'b0, 1'b1); chk_pulses("g1i", 4'b0000, 1'b0, 1'b0, 1'b1); chk_y("g1i", 32'hD4C3_E2E1);
    send(8'hE3, 1'b1, 1'b0); chk_pulses("g2", 4'b0100, 1'b0, 1'b0, 1'b1);
    send(8'h97, 1'b0, 1'b0); chk_pulses("g2i", 4'b0000, 1'b0, 1'b0, 1'b1);
    send(8'hE4, 1'b1, 1'b0); chk_pulses("g3", 4'b1000, 1'b1, 1'b0, 1'b1); chk_y("g3", 32'hE4E3_E2E1);

    // Missing marker
    send(8'h55, 1'b1, 1'b0); chk_pulses("mm", 4'b0000, 1'b0, 1'b1, 1'b0); chk_y("mm", 32'hE4E3_E2E1);
    send(8'h56, 1'b1, 1'b0); chk_pulses("mmh", 4'b0000, 1'b0, 1'b0, 1'b0); chk_y("mmh", 32'hE4E3_E2E1);
    send(8'h66, 1'b1, 1'b1); chk_pulses("mr0", 4'b0001, 1'b0, 1'b0, 1'b1); chk_y("mr0", 32'hE4E3_E266);
    send(8'h67, 1'b1, 1'b0);
    send(8'h68, 1'b1, 1'b0);
    send(8'h69, 1'b1, 1'b0); chk_pulses("mr3", 4'b1000, 1'b1, 1'b0, 1'b1); chk_y("mr3", 32'h6968_6766);

    // Early marker
    send(8'h10, 1'b1, 1'b1); chk_pulses("e0", 4'b0001, 1'b0, 1'b0, 1'b1);
    send(8'h11, 1'b1, 1'b0); chk_pulses("e1", 4'b0010, 1'b0, 1'b0, 1'b1);
    send(8'h20, 1'b1, 1'b1); chk_pulses("em", 4'b0001, 1'b0, 1'b1, 1'b1); chk_y("em", 32'h6968_1120);
    send(8'h21, 1'b1, 1'b0); chk_pulses("e21", 4'b0010, 1'b0, 1'b0, 1'b1);
    send(8'h22, 1'b1, 1'b0); chk_pulses("e22", 4'b0100, 1'b0, 1'b0, 1'b1);
    send(8'h23, 1'b1, 1'b0); chk_pulses("e23", 4'b1000, 1'b1, 1'b0, 1'b1); chk_y("e23", 32'h2322_2120);

    // Back-to-back frames
    for (int i = 0; i < 12; i++) begin
      send(8'h80 + 8'(i), 1'b1, (i % 4) == 0);
      chk_pulses($sformatf("bb%0d", i), 4'b0001 << (i % 4), (i % 4) == 3, 1'b0, 1'b1);
    end
    chk_y("bb", 32'h8B8A_8988);

    // Reset mid-frame, asserted between edges
    send(8'h30, 1'b1, 1'b1);
    send(8'h31, 1'b1, 1'b0); chk_y("pre", 32'h8B8A_3130);
    #2;
    rst_n = 1'b0;
    #1;
    chk_y("arst", 32'h0000_0000);
    chk_pulses("arst", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h40, 1'b1, 1'b0); chk_pulses("posth", 4'b0000, 1'b0, 1'b0, 1'b0); chk_y("posth", 32'h0000_0000);
    send(8'h41, 1'b1, 1'b1); chk_pulses("postl", 4'b0001, 1'b0, 1'b0, 1'b1); chk_y("postl", 32'h0000_0041);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- 1-to-4 time-division demultiplexer; the receive-side counterpart of the team's 4:1 channel mux.
- Accepts one serial stream of WIDTH-bit samples with a frame marker on slot 0.
- Steers samples in slot order to four registered channel outputs.
- Tracks frame alignment with a hunt/lock state machine and flags sync errors.

Parameters:
- WIDTH, 8, bit width of each sample and each channel output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  incoming sample.
- din_valid  input  1  din carries a sample this cycle.
- frame  input  1  qualifies the sample as slot 0 of a frame; only meaningful when din_valid=1.
- y0  output  WIDTH  channel 0 register (slot 0).
- y1  output  WIDTH  channel 1 register (slot 1).
- y2  output  WIDTH  channel 2 register (slot 2).
- y3  output  WIDTH  channel 3 register (slot 3).
- yv  output  4  one-hot pulse; bit k high for one cycle when yk was updated.
- frame_done  output  1  one-cycle pulse when slot 3 of a frame is written.
- sync_err  output  1  one-cycle pulse on an alignment violation.
- locked  output  1  state machine is in LOCK.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - y0..y3=0, yv=0, frame_done=0, sync_err=0, locked=0.
  - Internal slot counter=0; state=HUNT.
  - Deassertion is sampled on clk; no output changes until the first edge with rst_n=1.
- Reset mid-frame discards the partial frame. Channel registers are cleared, not held.
- All outputs are registered. A sample accepted on edge N appears on yk, with its yv bit, after edge N. Latency is 1 cycle.
- yv, frame_done and sync_err are single-cycle pulses, deasserted on any cycle without a qualifying event.
- Cycles with din_valid=0 change nothing except clearing the pulses. frame is ignored when din_valid=0.
- State HUNT (locked=0):
  - din_valid=1, frame=0: sample dropped, no pulse, stay HUNT.
  - din_valid=1, frame=1: y0<=din, yv=0001, slot<=1, go LOCK.
- State LOCK (locked=1):
  - din_valid=1, frame=0, slot in 1..3: y[slot]<=din, yv=one-hot(slot), slot<=slot+1 mod 4.
  - When slot=3 is written: frame_done=1 in the same output cycle as yv=1000, and slot wraps to 0.
  - din_valid=1, frame=1, slot=0: normal frame start. y0<=din, yv=0001, slot<=1.
  - din_valid=1, frame=0, slot=0 (missing marker): sync_err=1, sample dropped, no yv, slot stays 0, go HUNT.
  - din_valid=1, frame=1, slot in 1..3 (early marker, short frame): sync_err=1, remaining channels of the old frame keep their stale values, no frame_done.
  - Early-marker resync: y0<=din, yv=0001, slot<=1, stay LOCK.
- Channels not written in a cycle hold their value. At most one yk updates per cycle.
- sync_err and yv may assert in the same cycle (early-marker resync only).

Test Plan:
- Reset mid-frame: lock, accept 2 samples, pull rst_n low asynchronously between edges -> all outputs 0 immediately, locked=0. After release, a frame=0 sample is dropped (HUNT).
- Clean frame, WIDTH=8: valid samples 0xA1(frame=1), 0xB2, 0xC3, 0xD4 on consecutive cycles -> y0..y3 = A1,B2,C3,D4. yv = 0001,0010,0100,1000 one cycle later each. frame_done high only alongside yv=1000. locked=1 from the first output cycle.
- Gaps: same frame with din_valid=0 cycles interleaved -> identical final y values, yv pulses only on valid cycles, slot order unchanged.
- Missing marker: after a full frame, send 0x55 with frame=0 -> sync_err=1, y0 unchanged, locked=0. Next frame=1 sample 0x66 -> y0=0x66, locked=1.
- Early marker: frame 0x10(f=1), 0x11, then 0x20(f=1) -> sync_err=1 with yv=0001, y0=0x20, y1=0x11, y2/y3 unchanged, no frame_done. Then 0x21,0x22,0x23 -> frame_done.
- Back-to-back frames: 3 consecutive frames without gaps -> frame_done every 4th valid cycle, no sync_err, locked stays 1.
